// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - two-requester round-robin controller for a shared repeated-addition multiplier
module mul_share_ctrl #(
  parameter int W  = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [W-1:0]  a0,
  input  logic [W-1:0]  b0,
  input  logic [W-1:0]  a1,
  input  logic [W-1:0]  b1,
  input  logic          eqz,
  input  logic [PW-1:0] p_in,
  output logic          LdA,
  output logic          LdB,
  output logic          LdP,
  output logic          clrP,
  output logic          decB,
  output logic [W-1:0]  data_out,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [PW-1:0] result,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, LDA, LDB, MUL} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_gnt;
  logic [1:0]    r_done;
  logic          r_last;
  logic [W-1:0]  r_opa;
  logic [W-1:0]  r_opb;
  logic [PW-1:0] r_result;
  logic [1:0]    w_elig;
  logic [1:0]    w_win;

  // A requester that just completed is masked for one cycle so the other side gets a turn.
  always_comb begin
    w_elig = req & ~r_done;
    w_win  = 2'b00;
    case (w_elig)
      2'b01:   w_win = 2'b01;
      2'b10:   w_win = 2'b10;
      2'b11:   w_win = r_last ? 2'b01 : 2'b10;
      default: w_win = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    LdA      = 1'b0;
    LdB      = 1'b0;
    LdP      = 1'b0;
    clrP     = 1'b0;
    decB     = 1'b0;
    data_out = '0;
    case (r_state)
      IDLE: if (|w_elig) w_next = LDA;
      LDA: begin
        LdA      = 1'b1;
        data_out = r_opa;
        w_next   = LDB;
      end
      LDB: begin
        LdB      = 1'b1;
        clrP     = 1'b1;
        data_out = r_opb;
        w_next   = MUL;
      end
      MUL: begin
        LdP  = ~eqz;
        decB = ~eqz;
        if (eqz) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // r_last holds 1 when requester 1 was served last, so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt    <= 2'b00;
      r_done   <= 2'b00;
      r_last   <= 1'b1;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else begin
      r_done <= 2'b00;
      if (r_state == IDLE && |w_elig) begin
        r_gnt  <= w_win;
        r_last <= w_win[1];
        r_opa  <= w_win[0] ? a0 : a1;
        r_opb  <= w_win[0] ? b0 : b1;
      end
      if (r_state == MUL && eqz) begin
        r_result <= p_in;
        r_done   <= r_gnt;
        r_gnt    <= 2'b00;
      end
    end
  end

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign result = r_result;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - scoreboard bench for mul_share_ctrl with a behavioural A/B/P datapath
module tb_mul_share_ctrl;

  localparam int W  = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          eqz;
  logic [PW-1:0] p_in;
  logic          LdA, LdB, LdP, clrP, decB;
  logic [W-1:0]  data_out;
  logic [1:0]    gnt, done;
  logic [PW-1:0] result;
  logic          busy;

  logic [W-1:0]  dp_a = '0;
  logic [W-1:0]  dp_b = '0;
  logic [PW-1:0] dp_p = '0;

  typedef struct {
    logic [1:0]    g;
    logic [PW-1:0] res;
    int            n;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         gcyc = 0;
  int         ldp_cnt = 0;
  logic [1:0] prev_gnt = 2'b00;

  always #5 clk = ~clk;

  mul_share_ctrl #(.W(W), .PW(PW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .eqz(eqz), .p_in(p_in),
    .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
    .data_out(data_out), .gnt(gnt), .done(done), .result(result), .busy(busy)
  );

  always @(posedge clk) begin
    if (LdA) dp_a <= data_out;
    if (LdB) dp_b <= data_out;
    else if (decB) dp_b <= dp_b - 1'b1;
    if (clrP) dp_p <= '0;
    else if (LdP) dp_p <= dp_p + PW'(dp_a);
  end
  assign eqz  = (dp_b == '0);
  assign p_in = dp_p;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (gnt != 2'b00 && prev_gnt == 2'b00) begin
        gcyc    = cyc;
        ldp_cnt = 0;
      end
      if (LdP) ldp_cnt++;
      if (done != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("done", 32'(done), 32'(e.g));
          check("result", 32'(result), 32'(e.res));
          check("latency", 32'(cyc - gcyc), 32'(e.n + 3));
          check("ldp_cycles", 32'(ldp_cnt), 32'(e.n));
        end
      end
    end
    prev_gnt = gnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (done != 2'b00) return;
    end
    check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic push(input logic [1:0] g, input int res, input int n);
    exp_t e;
    e.g   = g;
    e.res = PW'(res);
    e.n   = n;
    sb_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ctrl", 32'({LdA, LdB, LdP, clrP, decB}), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    rst = 1'b0;
    tick();

    // Single requester 0: 5*3
    a0 = 8'd5; b0 = 8'd3; req = 2'b01;
    push(2'b01, 15, 3);
    tick();
    check("gnt0", 32'(gnt), 32'd1);
    check("busy_lda", 32'(busy), 32'd1);
    check("lda_ctrl", 32'({LdA, LdB, LdP, clrP, decB}), 32'b10000);
    check("lda_data", 32'(data_out), 32'd5);
    tick();
    check("ldb_ctrl", 32'({LdA, LdB, LdP, clrP, decB}), 32'b01010);
    check("ldb_data", 32'(data_out), 32'd3);
    wait_done(40);
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_data", 32'(data_out), 32'd0);
    req = 2'b00;
    tick();

    // Requester 1 with b=0
    a1 = 8'd9; b1 = 8'd0; req = 2'b10;
    push(2'b10, 0, 0);
    wait_done(40);
    req = 2'b00;
    tick();

    // Tie after reset: requester 0 first, then requester 1
    rst = 1'b1; tick(); rst = 1'b0;
    a0 = 8'd2; b0 = 8'd2; a1 = 8'd7; b1 = 8'd4; req = 2'b11;
    push(2'b01, 4, 2);
    push(2'b10, 28, 4);
    wait_done(40);
    tick();
    check("tie_second_gnt", 32'(gnt), 32'd2);
    wait_done(40);
    req = 2'b00;
    tick();

    // Four back-to-back operations with both requests held
    a0 = 8'd3; b0 = 8'd2; a1 = 8'd4; b1 = 8'd1; req = 2'b11;
    push(2'b01, 6, 2); push(2'b10, 4, 1); push(2'b01, 6, 2); push(2'b10, 4, 1);
    for (int k = 0; k < 4; k++) begin
      wait_done(40);
      check("rr_idle_gnt", 32'(gnt), 32'd0);
      if (k == 3) begin
        req = 2'b00;
      end else begin
        tick();
        check("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'd2 : 32'd1);
      end
    end
    tick();

    // Reset in the middle of MUL abandons the operation
    a0 = 8'd6; b0 = 8'd5; req = 2'b01;
    repeat (5) tick();
    check("mul_busy", 32'(busy), 32'd1);
    rst = 1'b1; req = 2'b00;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_ctrl", 32'({LdA, LdB, LdP, clrP, decB}), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("abort_no_done", 32'(done), 32'd0);
    req = 2'b01;
    push(2'b01, 30, 5);
    wait_done(40);
    req = 2'b00;
    tick();

    // Request dropped and operands changed after grant
    a0 = 8'd4; b0 = 8'd4; req = 2'b01;
    push(2'b01, 16, 4);
    tick();
    req = 2'b00; a0 = 8'd1; b0 = 8'd7;
    wait_done(40);
    repeat (4) tick();
    check("result_hold", 32'(result), 32'd16);
    check("final_busy", 32'(busy), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
